// File: rtl/fifo_shift_pkg.sv
// Shared defaults, stage-select encoding and counter sizing for the shift-register FIFO.
package fifo_shift_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_SHIFT = 2'd2
    } sel_e;

    // Occupancy must reach FIFO_DEPTH itself, hence one bit more than the index width.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_shift_stage.sv
// One FIFO entry: holds, loads the write word, or takes its upstream neighbour's word.
module fifo_shift_stage
    import fifo_shift_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  sel_e                  sel_i,
    input  logic [DATA_WIDTH-1:0] load_i,
    input  logic [DATA_WIDTH-1:0] shift_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        unique case (sel_i)
            SEL_LOAD:  data_d = load_i;
            SEL_SHIFT: data_d = shift_i;
            default:   data_d = data_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/fifo_shift.sv
// Show-ahead FIFO built from a chain of shift stages; entry 0 is always the oldest word.
module fifo_shift
    import fifo_shift_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic                  wr_ready,
    output logic                  rd_val,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int CW = cnt_width(FIFO_DEPTH);

    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic [CW-1:0]         count_m1;
    logic                  wr_acc;
    logic                  rd_acc;
    sel_e                  sel   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] entry [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] nbr   [FIFO_DEPTH];

    assign wr_ready = (count_q != CW'(FIFO_DEPTH));
    assign rd_val   = (count_q != '0);
    assign rd_data  = rd_val ? entry[0] : '0;

    assign wr_acc   = wr_en && wr_ready;
    assign rd_acc   = rd_en && rd_val;
    assign count_m1 = count_q - CW'(1);

    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_m1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // On a pop every stage shifts; a concurrent write lands one slot lower than it would alone.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            sel[i] = SEL_HOLD;
            if (rd_acc) begin
                if (wr_acc && (count_m1 == CW'(i))) begin
                    sel[i] = SEL_LOAD;
                end else begin
                    sel[i] = SEL_SHIFT;
                end
            end else if (wr_acc && (count_q == CW'(i))) begin
                sel[i] = SEL_LOAD;
            end
        end
    end

    for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_stage
        if (g == FIFO_DEPTH - 1) begin : g_tail
            assign nbr[g] = '0;
        end else begin : g_body
            assign nbr[g] = entry[g+1];
        end

        fifo_shift_stage #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .sel_i  (sel[g]),
            .load_i (wr_data),
            .shift_i(nbr[g]),
            .data_o (entry[g])
        );
    end

endmodule

// File: tb/tb_fifo_shift.sv
// Directed bench for fifo_shift with default parameters (8-bit words, 4 entries).
module tb_fifo_shift;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       wr_ready;
    logic       rd_val;
    logic [7:0] rd_data;

    int n_checks;
    int n_fail;

    fifo_shift dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .wr_ready(wr_ready),
        .rd_val  (rd_val),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_data = 8'h00;
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (rd_val !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rd_val: got %b expected 0", rd_val);
        end
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wr_ready: got %b expected 1", wr_ready);
        end
        n_checks++;
        if (rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rd_data: got %h expected 00", rd_data);
        end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            wr_en = 1'b1;
            wr_data = 8'(k);
            tick();
            n_checks++;
            if (rd_val !== 1'b1 || rd_data !== 8'h00) begin
                n_fail++;
                $display("FAIL fill_head[%0d]: got val=%b data=%h expected val=1 data=00", k, rd_val, rd_data);
            end
            n_checks++;
            if (wr_ready !== (k < 3)) begin
                n_fail++;
                $display("FAIL fill_wr_ready[%0d]: got %b expected %b", k, wr_ready, (k < 3));
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_overflow();
        wr_en = 1'b1;
        wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (wr_ready !== 1'b0 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL overflow_drop: got ready=%b data=%h expected ready=0 data=00", wr_ready, rd_data);
        end
    endtask

    task automatic test_drain();
        rd_en = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'hBB;
        #1;
        n_checks++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_no_bypass: got wr_ready=%b expected 0", wr_ready);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rd_val !== 1'b1 || rd_data !== 8'(k)) begin
                n_fail++;
                $display("FAIL drain[%0d]: got val=%b data=%h expected val=1 data=%h", k, rd_val, rd_data, 8'(k));
            end
            tick();
            wr_en = 1'b0;
        end
        rd_en = 1'b0;
        n_checks++;
        if (rd_val !== 1'b0 || rd_data !== 8'h00 || wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_empty: got val=%b data=%h ready=%b expected 0/00/1", rd_val, rd_data, wr_ready);
        end
    endtask

    task automatic test_empty_read();
        rd_en = 1'b1;
        tick();
        n_checks++;
        if (rd_val !== 1'b0 || wr_ready !== 1'b1 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL empty_read: got val=%b ready=%b data=%h expected 0/1/00", rd_val, wr_ready, rd_data);
        end
        wr_en = 1'b1;
        wr_data = 8'h55;
        n_checks++;
        if (rd_val !== 1'b0) begin
            n_fail++;
            $display("FAIL write_latency: got rd_val=%b before edge expected 0", rd_val);
        end
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (rd_val !== 1'b1 || rd_data !== 8'h55) begin
            n_fail++;
            $display("FAIL empty_rw: got val=%b data=%h expected val=1 data=55", rd_val, rd_data);
        end
        tick();
        rd_en = 1'b0;
        n_checks++;
        if (rd_val !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_rw_pop: got rd_val=%b expected 0", rd_val);
        end
    endtask

    task automatic test_back_to_back();
        wr_en = 1'b1;
        wr_data = 8'h05;
        tick();
        wr_data = 8'h06;
        tick();
        n_checks++;
        if (rd_data !== 8'h05) begin
            n_fail++;
            $display("FAIL b2b_head: got %h expected 05", rd_data);
        end
        rd_en = 1'b1;
        wr_data = 8'h07;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (rd_val !== 1'b1 || rd_data !== 8'h06 || wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_simul: got val=%b data=%h ready=%b expected 1/06/1", rd_val, rd_data, wr_ready);
        end
        tick();
        n_checks++;
        if (rd_val !== 1'b1 || rd_data !== 8'h07) begin
            n_fail++;
            $display("FAIL b2b_second: got val=%b data=%h expected val=1 data=07", rd_val, rd_data);
        end
        tick();
        rd_en = 1'b0;
        n_checks++;
        if (rd_val !== 1'b0 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL b2b_count: got val=%b data=%h expected val=0 data=00", rd_val, rd_data);
        end
    endtask

    task automatic test_async_reset();
        wr_en = 1'b1;
        wr_data = 8'h11;
        tick();
        wr_data = 8'h22;
        tick();
        wr_data = 8'h33;
        tick();
        wr_en = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if (rd_val !== 1'b0 || wr_ready !== 1'b1 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: got val=%b ready=%b data=%h expected 0/1/00", rd_val, wr_ready, rd_data);
        end
        tick();
        reset = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h44;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (rd_val !== 1'b1 || rd_data !== 8'h44) begin
            n_fail++;
            $display("FAIL post_reset_write: got val=%b data=%h expected val=1 data=44", rd_val, rd_data);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_empty_read();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_shift.md
FIFO_SHIFT -- requirements
Module: fifo_shift

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of each data word.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of entries; legal range is 2 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-006 The block SHALL have port wr_data, input, DATA_WIDTH bits: write data.
REQ-007 The block SHALL have port rd_en, input, 1 bit: read request (pop).
REQ-008 The block SHALL have port wr_ready, output, 1 bit: high when a write can be accepted (not full).
REQ-009 The block SHALL have port rd_val, output, 1 bit: high when rd_data holds a valid entry (not empty).
REQ-010 The block SHALL have port rd_data, output, DATA_WIDTH bits: oldest entry, shown ahead of the pop.

Function
REQ-011 Storage SHALL be a shift register of FIFO_DEPTH entries; entry 0 is the head (oldest).
REQ-012 An occupancy counter of $clog2(FIFO_DEPTH)+1 bits SHALL track the count, range 0..FIFO_DEPTH.
REQ-013 wr_ready SHALL equal (count != FIFO_DEPTH) and rd_val SHALL equal (count != 0), both decoded combinationally from registered state.
REQ-014 rd_data SHALL equal entry 0 when rd_val=1 and all zeros when rd_val=0, with zero latency (show-ahead).
REQ-015 A write SHALL be accepted only on a rising edge with wr_en=1 and wr_ready=1; wr_data is stored at index count, and count increments.
REQ-016 A read SHALL be accepted only on a rising edge with rd_en=1 and rd_val=1; all entries shift one place toward index 0, and count decrements.
REQ-017 With a simultaneous accepted read and write, the block SHALL shift, store wr_data at index count-1, and leave count unchanged.
REQ-018 When full, wr_ready SHALL stay 0 even if rd_en=1 in the same cycle (no full-bypass); a write with wr_ready=0 SHALL be dropped with no state change.
REQ-019 When empty, rd_en SHALL be ignored; a simultaneous write SHALL be accepted normally, and its data is visible on rd_data the following cycle.
REQ-020 Data order SHALL be strictly first-in first-out; no entry is lost or duplicated.
REQ-021 A written word SHALL be readable no earlier than the cycle after the write is accepted (1-cycle write-to-read latency).

Reset
REQ-022 While reset=0, count and all entries SHALL clear asynchronously to 0, giving rd_val=0, wr_ready=1 and rd_data=0.
REQ-023 Reset release SHALL be synchronous to clk; the first write is accepted on the first rising edge after release.
REQ-024 Reset asserted mid-operation SHALL discard all contents immediately.

Structure
REQ-025 Default DATA_WIDTH/FIFO_DEPTH constants and the counter-width function SHALL live in shared package fifo_shift_pkg.
REQ-026 One sub-module, fifo_shift_stage (one register entry with load-from-input / load-from-neighbour / hold select), SHALL be instantiated FIFO_DEPTH times by generate.
REQ-027 Control logic (count, accept decode, per-stage select) SHALL reside in fifo_shift.

Verification
REQ-028 Reset low for 1 cycle, then release -> rd_val=0, wr_ready=1, rd_data=0.
REQ-029 wr_en=1 for 4 cycles with wr_data 0,1,2,3 -> wr_ready=0 after the 4th edge, rd_val=1, rd_data=0.
REQ-030 From full, rd_en=1 for 4 cycles -> rd_data 0,1,2,3 on successive cycles, then rd_val=0, rd_data=0, wr_ready=1.
REQ-031 When full, write 0xAA -> dropped; a later drain still yields 0,1,2,3; rd_en while empty -> no state change.
REQ-032 Holding 2 entries (5,6), read and write 7 together -> count stays 2; the drain yields 6 then 7.
REQ-033 Drive reset=0 asynchronously between edges while 3 entries are held -> outputs reset at once without waiting for a clock edge.
